// File: rtl/clk_duty_monitor_pkg.sv
// Shared types and defaults for the divided-clock duty/period monitor.
// Contents:
//   state_e        - measurement FSM state encoding
//   EXP_PERIOD_DEF - default expected period in clk cycles
//   EXP_HIGH_DEF   - default expected high time in clk cycles
package clk_duty_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEAS      = 2'd2
  } state_e;

  localparam int unsigned EXP_PERIOD_DEF = 5;
  localparam int unsigned EXP_HIGH_DEF   = 2;

endpackage

// File: rtl/clk_duty_monitor_sync_rise_det.sv
// Three-flop synchronizer with rising-edge detect for an asynchronous input.
// Ports:
//   clk  - sampling clock (posedge)
//   rst  - synchronous active-low reset, clears the whole chain
//   d    - asynchronous input
//   lvl  - synchronized level (second stage)
//   rise - one-cycle pulse when lvl goes 0 -> 1
module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic lvl,
  output logic rise
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign lvl  = s2_q;
  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/clk_duty_monitor.sv
// Measures period and high time of a divided clock in clk cycles, checks
// them against expected values, and reports lock / mismatch / stuck clock.
// Ports:
//   clk        - 100 MHz system clock (posedge)
//   rst        - synchronous active-low reset
//   en         - monitor enable; 0 returns to IDLE and drops lock
//   mon_in     - divided clock under test (asynchronous)
//   clr_err    - clears sticky err and timeout (a same-cycle set wins)
//   period     - last measured period
//   high_time  - last measured high time
//   meas_valid - one-cycle pulse when period/high_time update
//   locked     - LOCK_N consecutive matching measurements seen
//   err        - sticky, set on a mismatching measurement
//   timeout    - sticky, set when no rising edge arrives before saturation
module clk_duty_monitor
  import clk_duty_monitor_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned EXP_PERIOD = EXP_PERIOD_DEF,
  parameter int unsigned EXP_HIGH   = EXP_HIGH_DEF,
  parameter int unsigned TOL        = 0,
  parameter int unsigned LOCK_N     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mon_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam int unsigned      MC_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] EXP_H   = CNT_W'(EXP_HIGH);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_N);

  logic lvl, rise;

  sync_rise_det u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (mon_in),
    .lvl  (lvl),
    .rise (rise)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;
  logic             meas_valid_q, meas_valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             timeout_q, timeout_d;

  logic [CNT_W-1:0] per_diff, hi_diff;
  logic             is_match, set_err, set_to;

  always_comb begin
    // Smaller subtracted from larger so the deviation never wraps.
    per_diff = (per_cnt_q >= EXP_P) ? (per_cnt_q - EXP_P) : (EXP_P - per_cnt_q);
    hi_diff  = (hi_cnt_q >= EXP_H) ? (hi_cnt_q - EXP_H) : (EXP_H - hi_cnt_q);
    is_match = (per_diff <= TOL_C) && (hi_diff <= TOL_C);

    state_d      = state_q;
    per_cnt_d    = per_cnt_q;
    hi_cnt_d     = hi_cnt_q;
    match_cnt_d  = match_cnt_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    set_err      = 1'b0;
    set_to       = 1'b0;

    if (!en) begin
      state_d     = IDLE;
      per_cnt_d   = '0;
      hi_cnt_d    = '0;
      match_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          state_d   = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          // First edge only starts the count; no partial period is reported.
          if (rise) begin
            per_cnt_d = CNT_W'(1);
            hi_cnt_d  = CNT_W'(1);
            state_d   = MEAS;
          end
        end
        MEAS: begin
          // A rise takes priority over saturation: it is measured.
          if (rise) begin
            period_d     = per_cnt_q;
            high_time_d  = hi_cnt_q;
            meas_valid_d = 1'b1;
            per_cnt_d    = CNT_W'(1);
            hi_cnt_d     = CNT_W'(1);
            if (is_match) begin
              if (match_cnt_q != LOCK_C) match_cnt_d = match_cnt_q + MC_W'(1);
            end else begin
              match_cnt_d = '0;
              set_err     = 1'b1;
            end
          end else if (per_cnt_q == CNT_MAX) begin
            set_to      = 1'b1;
            match_cnt_d = '0;
            per_cnt_d   = '0;
            hi_cnt_d    = '0;
            state_d     = WAIT_EDGE;
          end else begin
            // per_cnt_q < CNT_MAX here, and hi_cnt never exceeds per_cnt.
            per_cnt_d = per_cnt_q + CNT_W'(1);
            hi_cnt_d  = (hi_cnt_q != CNT_MAX) ? (hi_cnt_q + CNT_W'(lvl)) : hi_cnt_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    locked_d  = (match_cnt_d == LOCK_C);
    err_d     = set_err | (err_q & ~clr_err);
    timeout_d = set_to | (timeout_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      hi_cnt_q     <= '0;
      match_cnt_q  <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      hi_cnt_q     <= hi_cnt_d;
      match_cnt_q  <= match_cnt_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign period     = period_q;
  assign high_time  = high_time_q;
  assign meas_valid = meas_valid_q;
  assign locked     = locked_q;
  assign err        = err_q;
  assign timeout    = timeout_q;

endmodule
